// File: rtl/user_io_pkg.sv
// user_io_pkg: command codes, event types, FIFO entry width and SPI framing states
// shared by user_io_sync and its event FIFO.
package user_io_pkg;

  localparam logic [7:0] CMD_BUT_SW    = 8'h01;
  localparam logic [7:0] CMD_JOY0      = 8'h02;
  localparam logic [7:0] CMD_JOY1      = 8'h03;
  localparam logic [7:0] CMD_MOUSE     = 8'h04;
  localparam logic [7:0] CMD_KEY       = 8'h05;
  localparam logic [7:0] CMD_OSD       = 8'h06;
  localparam logic [7:0] CMD_STATUS_RD = 8'h07;
  localparam logic [7:0] CMD_JOY2      = 8'h10;
  localparam logic [7:0] CMD_JOY3      = 8'h11;
  localparam logic [7:0] CMD_STATUS_WR = 8'h1E;

  localparam int unsigned EV_W = 10;

  typedef enum logic [1:0] {
    EV_MOUSE_X = 2'd0,
    EV_MOUSE_Y = 2'd1,
    EV_KEY     = 2'd2,
    EV_OSD     = 2'd3
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD
  } spi_state_e;

  // Returns {hit, joystick index} for a joystick command code.
  function automatic logic [2:0] joy_decode(input logic [7:0] cmd);
    case (cmd)
      CMD_JOY0: return {1'b1, 2'd0};
      CMD_JOY1: return {1'b1, 2'd1};
      CMD_JOY2: return {1'b1, 2'd2};
      CMD_JOY3: return {1'b1, 2'd3};
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/user_io_fifo.sv
// user_io_fifo: synchronous first-word-fall-through FIFO with an overflow (dropped push) pulse.
module user_io_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LVL_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign full     = (r_count == LVL_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_pop_ok = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
  assign w_push_ok = push & (~full | w_pop_ok);
  assign overflow  = push & ~w_push_ok;
  assign pop_data  = r_mem[r_rd_ptr];
  assign level     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/user_io_sync.sv
// user_io_sync: oversampled SPI user-I/O slave (joysticks, buttons, event FIFO).
// Optional STATUS register build: define USER_IO_STATUS_EN.
module user_io_sync
  import user_io_pkg::*;
#(
  parameter int unsigned NUM_JOY    = 2,
  parameter int unsigned JOY_W      = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LVL_W      = 6
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     SPI_CLK,
  input  logic                     SPI_SS_IO,
  input  logic                     SPI_MOSI,
  output logic                     SPI_MISO,
  input  logic [7:0]               CORE_TYPE,
  output logic [NUM_JOY*JOY_W-1:0] JOY,
  output logic [1:0]               BUTTONS,
  output logic [1:0]               SWITCHES,
  output logic [3:0]               CONF,
  output logic [2:0]               MOUSE_BUTTONS,
  output logic                     EV_VALID,
  input  logic                     EV_READY,
  output logic [1:0]               EV_TYPE,
  output logic [7:0]               EV_DATA,
  output logic                     EV_OVERFLOW,
  input  logic                     OVF_CLR
`ifdef USER_IO_STATUS_EN
  ,
  output logic [31:0]              STATUS
`endif
);

  logic [1:0]       r_sck_sync, r_ss_sync, r_mosi_sync;
  logic             r_sck_d;
  spi_state_e       r_state, w_state_nxt;
  logic [2:0]       r_bit_cnt;
  logic [4:0]       r_byte_idx;
  logic [6:0]       r_shift;
  logic [7:0]       r_cmd, r_but_sw, r_stat_byte;
  logic [2:0]       r_mouse_btn;
  logic [JOY_W-1:0] r_joy [NUM_JOY];
  logic             r_miso, r_ovf;
  logic             w_sck_rise, w_sck_fall, w_ss, w_mosi;
  logic             w_bit_stb, w_byte_done, w_payload_done;
  logic [7:0]       w_byte, w_status;
  logic             w_joy_hit;
  logic [1:0]       w_joy_idx;
  logic             w_push, w_full, w_empty, w_drop;
  ev_type_e         w_push_type;
  logic [EV_W-1:0]  w_pop_data;
  logic [LVL_W-1:0] w_level;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], SPI_CLK};
      r_ss_sync   <= {r_ss_sync[0], SPI_SS_IO};
      r_mosi_sync <= {r_mosi_sync[0], SPI_MOSI};
      r_sck_d     <= r_sck_sync[1];
    end
  end

  assign w_sck_rise     = r_sck_sync[1] & ~r_sck_d;
  assign w_sck_fall     = ~r_sck_sync[1] & r_sck_d;
  assign w_ss           = r_ss_sync[1];
  assign w_mosi         = r_mosi_sync[1];
  assign w_bit_stb      = w_sck_rise & ~w_ss & (r_state != ST_IDLE);
  assign w_byte_done    = w_bit_stb & (r_bit_cnt == 3'd7);
  assign w_payload_done = w_byte_done & (r_state == ST_PAYLOAD);
  assign w_byte         = {r_shift, w_mosi};
  assign {w_joy_hit, w_joy_idx} = joy_decode(r_cmd);

  always_comb begin
    w_state_nxt = r_state;
    if (w_ss) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_CMD;
        ST_CMD:  if (w_byte_done) w_state_nxt = ST_PAYLOAD;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_cmd      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ss) begin
        r_bit_cnt  <= '0;
        r_byte_idx <= '0;
        r_shift    <= '0;
      end else if (w_bit_stb) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte[6:0];
        if (w_byte_done && r_byte_idx != 5'd31) r_byte_idx <= r_byte_idx + 5'd1;
        if (w_byte_done && r_state == ST_CMD) r_cmd <= w_byte;
      end
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_type = EV_KEY;
    if (w_payload_done) begin
      case (r_cmd)
        CMD_MOUSE: begin
          if (r_byte_idx == 5'd1) begin
            w_push      = 1'b1;
            w_push_type = EV_MOUSE_X;
          end else if (r_byte_idx == 5'd2) begin
            w_push      = 1'b1;
            w_push_type = EV_MOUSE_Y;
          end
        end
        CMD_KEY: begin
          w_push      = 1'b1;
          w_push_type = EV_KEY;
        end
        CMD_OSD: begin
          w_push      = 1'b1;
          w_push_type = EV_OSD;
        end
        default: w_push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_but_sw    <= '0;
      r_mouse_btn <= '0;
      for (int unsigned j = 0; j < NUM_JOY; j++) r_joy[j] <= '0;
    end else if (w_payload_done) begin
      if (r_cmd == CMD_BUT_SW && r_byte_idx == 5'd1) r_but_sw <= w_byte;
      if (r_cmd == CMD_MOUSE && r_byte_idx == 5'd3) r_mouse_btn <= w_byte[2:0];
      // Joystick indices at or above NUM_JOY never match the loop and are dropped.
      for (int unsigned j = 0; j < NUM_JOY; j++) begin
        if (w_joy_hit && 32'(w_joy_idx) == j) begin
          if (r_byte_idx == 5'd1) r_joy[j][7:0] <= w_byte;
          else if (JOY_W == 16 && r_byte_idx == 5'd2) r_joy[j][JOY_W-1 -: 8] <= w_byte;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_JOY; g++) begin : g_joy
    assign JOY[g*JOY_W +: JOY_W] = r_joy[g];
  end

`ifdef USER_IO_STATUS_EN
  logic [31:0] r_status;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_status <= '0;
    end else if (w_payload_done && r_cmd == CMD_STATUS_WR &&
                 r_byte_idx >= 5'd1 && r_byte_idx <= 5'd4) begin
      r_status[(32'(r_byte_idx) - 32'd1) * 8 +: 8] <= w_byte;
    end
  end
  assign STATUS = r_status;
`endif

  user_io_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (w_push),
    .push_data ({w_push_type, w_byte}),
    .pop       (EV_READY),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level),
    .overflow  (w_drop)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
    else if (OVF_CLR) r_ovf <= 1'b0;
  end

  assign w_status = {r_ovf, 7'(w_level)};

  // Bit 0 of the command byte has no preceding falling edge, so it is loaded on SS fall.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_miso      <= 1'b0;
      r_stat_byte <= '0;
    end else if (w_ss) begin
      r_miso <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_miso <= CORE_TYPE[7];
    end else if (w_sck_fall) begin
      if (r_state == ST_CMD) begin
        r_miso <= CORE_TYPE[3'd7 - r_bit_cnt];
      end else if (r_cmd == CMD_STATUS_RD) begin
        if (r_bit_cnt == 3'd0) begin
          r_stat_byte <= w_status;
          r_miso      <= w_status[7];
        end else begin
          r_miso <= r_stat_byte[3'd7 - r_bit_cnt];
        end
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign SPI_MISO      = r_miso;
  assign BUTTONS       = r_but_sw[1:0];
  assign SWITCHES      = r_but_sw[3:2];
  assign CONF          = r_but_sw[7:4];
  assign MOUSE_BUTTONS = r_mouse_btn;
  assign EV_VALID      = ~w_empty;
  assign {EV_TYPE, EV_DATA} = w_pop_data;
  assign EV_OVERFLOW   = r_ovf;

endmodule

// File: tb/tb_user_io_sync.sv
// tb_user_io_sync: vector table, corner sequences and random transfers checked against a
// rule-level model of user_io_sync (NUM_JOY=3, JOY_W=16, FIFO_DEPTH=8).
module tb_user_io_sync;

  localparam int unsigned NJ    = 3;
  localparam int unsigned JW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = 6;
  localparam int          HALF  = 50;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             SPI_CLK = 1'b0;
  logic             SPI_SS_IO = 1'b1;
  logic             SPI_MOSI = 1'b0;
  logic             SPI_MISO;
  logic [7:0]       CORE_TYPE = 8'hA3;
  logic [NJ*JW-1:0] JOY;
  logic [1:0]       BUTTONS, SWITCHES;
  logic [3:0]       CONF;
  logic [2:0]       MOUSE_BUTTONS;
  logic             EV_VALID;
  logic             EV_READY = 1'b0;
  logic [1:0]       EV_TYPE;
  logic [7:0]       EV_DATA;
  logic             EV_OVERFLOW;
  logic             OVF_CLR = 1'b0;
`ifdef USER_IO_STATUS_EN
  logic [31:0]      STATUS;
`endif

  user_io_sync #(
    .NUM_JOY    (NJ),
    .JOY_W      (JW),
    .FIFO_DEPTH (DEPTH),
    .LVL_W      (LW)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .SPI_CLK       (SPI_CLK),
    .SPI_SS_IO     (SPI_SS_IO),
    .SPI_MOSI      (SPI_MOSI),
    .SPI_MISO      (SPI_MISO),
    .CORE_TYPE     (CORE_TYPE),
    .JOY           (JOY),
    .BUTTONS       (BUTTONS),
    .SWITCHES      (SWITCHES),
    .CONF          (CONF),
    .MOUSE_BUTTONS (MOUSE_BUTTONS),
    .EV_VALID      (EV_VALID),
    .EV_READY      (EV_READY),
    .EV_TYPE       (EV_TYPE),
    .EV_DATA       (EV_DATA),
    .EV_OVERFLOW   (EV_OVERFLOW),
    .OVF_CLR       (OVF_CLR)
`ifdef USER_IO_STATUS_EN
    ,
    .STATUS        (STATUS)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_joy [4];
  logic [7:0]  m_but;
  logic [2:0]  m_mb;
  logic [31:0] m_status;
  logic        m_ovf;
  logic [9:0]  ev_q [$];
  logic [7:0]  tx_buf [32];
  logic [7:0]  rx_buf [32];
  logic [7:0]  exp_rx [32];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_joy[i] = '0;
    m_but = '0; m_mb = '0; m_status = '0; m_ovf = 1'b0;
    ev_q.delete();
  endtask

  task automatic model_push(input logic [9:0] v);
    if (ev_q.size() >= int'(DEPTH)) m_ovf = 1'b1;
    else ev_q.push_back(v);
  endtask

  task automatic model_xfer(input int nbytes);
    logic [7:0] c, d;
    int ji;
    c = tx_buf[0];
    ji = (c == 8'h02) ? 0 : (c == 8'h03) ? 1 : (c == 8'h10) ? 2 : (c == 8'h11) ? 3 : -1;
    for (int i = 1; i < nbytes; i++) begin
      d = tx_buf[i];
      exp_rx[i] = (c == 8'h07) ? {m_ovf, 7'(ev_q.size())} : 8'h00;
      if (c == 8'h01 && i == 1) m_but = d;
      if (ji >= 0 && ji < int'(NJ)) begin
        if (i == 1) m_joy[ji][7:0] = d;
        if (i == 2) m_joy[ji][15:8] = d;
      end
      if (c == 8'h04) begin
        if (i == 1) model_push({2'd0, d});
        if (i == 2) model_push({2'd1, d});
        if (i == 3) m_mb = d[2:0];
      end
      if (c == 8'h05) model_push({2'd2, d});
      if (c == 8'h06) model_push({2'd3, d});
`ifdef USER_IO_STATUS_EN
      if (c == 8'h1E && i <= 4) m_status[(i-1)*8 +: 8] = d;
`endif
    end
  endtask

  // SPI master, mode 0: MOSI changes while SCK low, MISO captured at SCK rise.
  task automatic ss_start();
    @(negedge CLK);
    SPI_SS_IO = 1'b0;
    #100;
  endtask

  task automatic ss_stop();
    #(2*HALF);
    SPI_SS_IO = 1'b1;
    #100;
  endtask

  task automatic spi_bits(input logic [7:0] data, input int nbits, input bit pop_last,
                          output logic [7:0] rx);
    rx = '0;
    for (int b = 7; b > 7 - nbits; b--) begin
      SPI_MOSI = data[b];
      #HALF;
      SPI_CLK = 1'b1;
      rx[b] = SPI_MISO;
      if (pop_last && b == 0) begin
        #20 EV_READY = 1'b1;
        #10 EV_READY = 1'b0;
        #20;
      end else begin
        #HALF;
      end
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic xfer(input int nbytes);
    logic [7:0] r;
    ss_start();
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(tx_buf[i], 8, 1'b0, r);
      rx_buf[i] = r;
    end
    ss_stop();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_joy"}, JOY, {m_joy[2], m_joy[1], m_joy[0]});
    check({tag, "_but_sw"}, {CONF, SWITCHES, BUTTONS}, m_but);
    check({tag, "_mouse_btn"}, MOUSE_BUTTONS, m_mb);
    check({tag, "_ovf"}, EV_OVERFLOW, m_ovf);
    check({tag, "_ev_valid"}, EV_VALID, ev_q.size() != 0);
`ifdef USER_IO_STATUS_EN
    check({tag, "_status"}, STATUS, m_status);
`endif
  endtask

  task automatic drain();
    while (ev_q.size() > 0) begin
      @(negedge CLK);
      check("drain_valid", EV_VALID, 1);
      check("drain_word", {EV_TYPE, EV_DATA}, ev_q[0]);
      EV_READY = 1'b1;
      @(negedge CLK);
      EV_READY = 1'b0;
      void'(ev_q.pop_front());
    end
    @(negedge CLK);
    check("drain_empty", EV_VALID, 0);
  endtask

  typedef struct {
    int          n;
    logic [39:0] bytes;
    logic [47:0] joy;
    logic [7:0]  but;
    logic [2:0]  mb;
    logic [7:0]  rx1;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input int n, input logic [39:0] b, input logic [47:0] joy,
                         input logic [7:0] but, input logic [2:0] mb, input logic [7:0] rx1);
    vec_t v;
    v.n = n; v.bytes = b; v.joy = joy; v.but = but; v.mb = mb; v.rx1 = rx1;
    vecs.push_back(v);
  endtask

  logic [7:0] cmds [12] = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h04,
                            8'h05, 8'h06, 8'h07, 8'h1E, 8'h09, 8'h3F};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int n;
    model_reset();
    #23;
    check("reset_outputs", {JOY, BUTTONS, SWITCHES, CONF, MOUSE_BUTTONS, EV_VALID,
                            EV_OVERFLOW, SPI_MISO}, '0);
    @(negedge CLK);
    RESET_N = 1'b1;
    #200;

    // Hand-computed transfer table starting from reset state.
    add_vec(2, 40'h01A5_000000, 48'h0000_0000_0000, 8'hA5, 3'd0, 8'h00);
    add_vec(3, 40'h023412_0000, 48'h0000_0000_1234, 8'hA5, 3'd0, 8'h00);
    add_vec(3, 40'h10CDAB_0000, 48'hABCD_0000_1234, 8'hA5, 3'd0, 8'h00);
    add_vec(3, 40'h115566_0000, 48'hABCD_0000_1234, 8'hA5, 3'd0, 8'h00);
    add_vec(2, 40'h0378_000000, 48'hABCD_0078_1234, 8'hA5, 3'd0, 8'h00);
    add_vec(4, 40'h0405FB03_00, 48'hABCD_0078_1234, 8'hA5, 3'd3, 8'h00);
    add_vec(2, 40'h09FF_000000, 48'hABCD_0078_1234, 8'hA5, 3'd3, 8'h00);
    add_vec(2, 40'h0700_000000, 48'hABCD_0078_1234, 8'hA5, 3'd3, 8'h02);
    foreach (vecs[v]) begin
      for (int k = 0; k < 5; k++) tx_buf[k] = vecs[v].bytes[39 - 8*k -: 8];
      model_xfer(vecs[v].n);
      xfer(vecs[v].n);
      check("vec_core_type", rx_buf[0], CORE_TYPE);
      check("vec_joy", JOY, vecs[v].joy);
      check("vec_but_sw", {CONF, SWITCHES, BUTTONS}, vecs[v].but);
      check("vec_mouse_btn", MOUSE_BUTTONS, vecs[v].mb);
      check("vec_rx1", rx_buf[1], vecs[v].rx1);
    end

    // Mouse events popped in order, then a pop on an empty FIFO.
    @(negedge CLK);
    check("mouse_ev0", {EV_VALID, EV_TYPE, EV_DATA}, {1'b1, 2'd0, 8'h05});
    EV_READY = 1'b1; @(negedge CLK); EV_READY = 1'b0;
    check("mouse_ev1", {EV_VALID, EV_TYPE, EV_DATA}, {1'b1, 2'd1, 8'hFB});
    EV_READY = 1'b1; @(negedge CLK);
    check("fifo_empty", EV_VALID, 0);
    @(negedge CLK); EV_READY = 1'b0;
    check("pop_empty", EV_VALID, 0);
    ev_q.delete();

    // Ten keycodes into an 8-deep FIFO: overflow, status read, clear.
    tx_buf[0] = 8'h05;
    for (int k = 1; k <= 10; k++) tx_buf[k] = 8'(k - 1);
    model_xfer(11);
    xfer(11);
    check("ovf_set", EV_OVERFLOW, 1);
    tx_buf[0] = 8'h07; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    model_xfer(3);
    xfer(3);
    check("status_rd_b1", rx_buf[1], 8'h88);
    check("status_rd_b2", rx_buf[2], 8'h88);
    @(negedge CLK); OVF_CLR = 1'b1; @(negedge CLK); OVF_CLR = 1'b0;
    m_ovf = 1'b0;
    check("ovf_clr", EV_OVERFLOW, 0);
    drain();

    // Fill to full, then push the ninth keycode in the same cycle as a pop.
    tx_buf[0] = 8'h05;
    for (int k = 1; k <= 8; k++) tx_buf[k] = 8'(8'h10 + k - 1);
    model_xfer(9);
    xfer(9);
    ss_start();
    spi_bits(8'h05, 8, 1'b0, r);
    spi_bits(8'h18, 8, 1'b1, r);
    ss_stop();
    void'(ev_q.pop_front());
    ev_q.push_back({2'd2, 8'h18});
    check("full_push_pop_ovf", EV_OVERFLOW, 0);
    drain();

    // Aborted joystick payload, then the next first byte is a command again.
    ss_start();
    spi_bits(8'h02, 8, 1'b0, r);
    spi_bits(8'hFF, 5, 1'b0, r);
    ss_stop();
    check_state("abort");
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h5A;
    model_xfer(2);
    xfer(2);
    check("after_abort_but_sw", {CONF, SWITCHES, BUTTONS}, 8'h5A);

`ifdef USER_IO_STATUS_EN
    tx_buf[0] = 8'h1E; tx_buf[1] = 8'hEF; tx_buf[2] = 8'hBE; tx_buf[3] = 8'hAD; tx_buf[4] = 8'hDE;
    model_xfer(5);
    xfer(5);
    check("status_wr", STATUS, 32'hDEADBEEF);
    tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    model_xfer(3);
    xfer(3);
    check("status_partial", STATUS, 32'hDEAD2211);
`endif

    // Reset in the middle of a command byte with an event queued.
    tx_buf[0] = 8'h05; tx_buf[1] = 8'hAA;
    model_xfer(2);
    xfer(2);
    check("pre_reset_valid", EV_VALID, 1);
    ss_start();
    spi_bits(8'h05, 2, 1'b0, r);
    RESET_N = 1'b0;
    #1;
    check("midreset_outputs", {JOY, BUTTONS, SWITCHES, CONF, MOUSE_BUTTONS, EV_VALID,
                               EV_OVERFLOW, SPI_MISO}, '0);
    model_reset();
    @(negedge CLK);
    SPI_SS_IO = 1'b1;
    #100;
    RESET_N = 1'b1;
    #200;
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h3C;
    model_xfer(2);
    xfer(2);
    check_state("post_reset");

    // Random transfers against the model; draining and clearing only occasionally.
    for (int it = 0; it < 30; it++) begin
      tx_buf[0] = cmds[$urandom_range(0, 11)];
      n = 1 + int'($urandom_range(1, 5));
      for (int k = 1; k < n; k++) tx_buf[k] = 8'($urandom);
      model_xfer(n);
      xfer(n);
      check("rnd_core_type", rx_buf[0], CORE_TYPE);
      for (int k = 1; k < n; k++) check("rnd_miso", rx_buf[k], exp_rx[k]);
      check_state("rnd");
      if ($urandom_range(0, 2) == 0) drain();
      if (m_ovf && $urandom_range(0, 1) == 1) begin
        @(negedge CLK); OVF_CLR = 1'b1; @(negedge CLK); OVF_CLR = 1'b0;
        m_ovf = 1'b0;
        check("rnd_ovf_clr", EV_OVERFLOW, 0);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/user_io_sync.md
Name: user_io_sync

Overview:
- Parametrised successor of the MiST user-I/O SPI slave; receives IO-controller commands over SPI (SPI_SS_IO, mode 0, MSB first).
- Runs entirely in the core clock domain: SPI pins are oversampled through synchronisers, not clocked by SPI_CLK.
- Supports 1-4 joysticks of 8 or 16 bits; keyboard/mouse events go into a FIFO with a valid/ready handshake instead of a one-cycle strobe.

Parameters:
- NUM_JOY, 2, number of joystick ports; legal range 1-4.
- JOY_W, 8, joystick width in bits; legal values 8 or 16.
- FIFO_DEPTH, 8, number of event FIFO entries; power of two, 2-32.
- LVL_W, 6, width of the FIFO level field; must be at least log2(FIFO_DEPTH)+1.

Ports:
- CLK  in  1  core clock; frequency at least 4x SPI_CLK.
- RESET_N  in  1  asynchronous active-low reset.
- SPI_CLK  in  1  SPI clock, asynchronous to CLK.
- SPI_SS_IO  in  1  active-low SPI select, asynchronous.
- SPI_MOSI  in  1  SPI data in, asynchronous.
- SPI_MISO  out  1  SPI data out.
- CORE_TYPE  in  8  core ID, shifted out during command byte.
- JOY  out  NUM_JOY*JOY_W  joystick states; joystick i occupies [i*JOY_W +: JOY_W].
- BUTTONS  out  2  but_sw[1:0].
- SWITCHES  out  2  but_sw[3:2].
- CONF  out  4  but_sw[7:4].
- MOUSE_BUTTONS  out  3  mouse button state.
- EV_VALID  out  1  event FIFO not empty.
- EV_READY  in  1  consumer pops the event when EV_VALID and EV_READY are both high.
- EV_TYPE  out  2  event type: 0 mouse X, 1 mouse Y, 2 keycode, 3 OSD key.
- EV_DATA  out  8  event payload.
- EV_OVERFLOW  out  1  sticky flag: an event was dropped.
- OVF_CLR  in  1  clears EV_OVERFLOW.

Behaviour:
- Reset (asynchronous, RESET_N low): every register and output is 0, including SPI_MISO, JOY, but_sw, MOUSE_BUTTONS, EV_OVERFLOW. The FIFO is emptied, so EV_VALID=0. Synchroniser flops also clear.
- Sync front end:
  - SPI_CLK, SPI_SS_IO and SPI_MOSI each pass through 2 flops.
  - A rising or falling SPI_CLK edge is detected as a one-CLK pulse from the synchronised history.
  - MOSI is sampled on the rising pulse; SPI_MISO is registered on the falling pulse.
- Framing:
  - Synchronised SS high resets the bit counter and byte index, and returns the FSM to IDLE. Any partial byte is discarded.
  - Bytes are counted from 0. Byte 0 is the command.
  - Bit counter is 3 bits and wraps 7->0. Byte index saturates at 31.
- FSM states: IDLE (SS high), CMD (collecting byte 0), PAYLOAD (byte 1 onward). Transitions: IDLE->CMD when SS falls; CMD->PAYLOAD on the 8th bit; any state->IDLE when SS rises.
- Latency: a completed byte updates its target register or pushes the FIFO 1 CLK after the rising-edge pulse of its 8th bit.
- Commands (codes held in the shared package):
  - 0x01: payload byte 1 -> but_sw.
  - 0x02 / 0x03 / 0x10 / 0x11: joystick 0 / 1 / 2 / 3. Byte 1 -> bits [7:0]. If JOY_W=16, byte 2 -> bits [15:8].
  - A joystick command with index >= NUM_JOY is ignored.
  - 0x04 (mouse): byte 1 pushes {0, data}; byte 2 pushes {1, data}; byte 3 bits [2:0] -> MOUSE_BUTTONS.
  - 0x05: every payload byte pushes {2, data}. Multi-byte keycodes are allowed.
  - 0x06: every payload byte pushes {3, data}.
  - 0x07 (status read): MISO shifts out {EV_OVERFLOW, FIFO level} zero-extended to 8 bits, MSB first, during every payload byte. The value is latched at the start of each byte.
  - Any other code is ignored; MISO outputs 0 during its payload.
- MISO: during byte 0, bit k (k = 0..7) outputs CORE_TYPE[7-k]; the value is set on the falling edge before that bit is sampled. Outside byte 0 and command 0x07, MISO is 0.
- FIFO boundary rules:
  - Push when full: the event is dropped, EV_OVERFLOW is set, and contents are unchanged.
  - Push and pop in the same cycle when full: the pop succeeds, the push is accepted, and overflow is not set.
  - Pop when empty: no effect.
  - EV_TYPE/EV_DATA are only valid while EV_VALID=1. They are first-word-fall-through, with no read latency.
  - OVF_CLR and a new overflow in the same cycle: the set wins.
- Reset mid-transfer returns to IDLE; the next byte after SS rises and falls again is treated as a command.

Optional Feature:
- USER_IO_STATUS_EN defined:
  - Adds output port STATUS [31:0], reset to 0.
  - Command 0x1E writes payload bytes 1-4 into STATUS[7:0], [15:8], [23:16], [31:24] (LSB first).
  - Each byte updates its STATUS slice independently, so an aborted transfer leaves the unwritten bytes unchanged.
- Not defined: no STATUS port; 0x1E is an ignored command.

Decomposition:
- Shared package user_io_pkg holds:
  - the command codes;
  - the event type codes (EV_MOUSE_X=0, EV_MOUSE_Y=1, EV_KEY=2, EV_OSD=3);
  - the event entry width (10 bits).
- Sub-module user_io_fifo:
  - synchronous FWFT FIFO parametrised by width and depth;
  - ports: push/pop/full/empty/level/overflow;
  - reset is asynchronous active-low.

Test Plan:
- After reset, SPI transfer of cmd 0x01 with byte 0xA5 -> MISO returns CORE_TYPE=0xA3 bits MSB first during byte 0; BUTTONS=1, SWITCHES=1, CONF=0xA.
- NUM_JOY=4, JOY_W=16, cmd 0x11 with bytes 0x34, 0x12 -> JOY[63:48]=0x1234, other joysticks 0. With NUM_JOY=2, the same transfer leaves JOY unchanged.
- Cmd 0x04 with bytes 0x05, 0xFB, 0x03, EV_READY held low -> FIFO holds {0,0x05} then {1,0xFB}; MOUSE_BUTTONS=3. Raising EV_READY pops 2 events in order.
- FIFO_DEPTH=8, cmd 0x05 with 10 bytes 0x00..0x09 and no pops -> 8 events (0x00..0x07) kept, EV_OVERFLOW=1. Cmd 0x07 read returns 0x88 (overflow bit 7 set, level 8). OVF_CLR pulse -> EV_OVERFLOW=0.
- SS raised after 5 bits of a cmd 0x02 payload -> joystick 0 unchanged. The next transfer decodes its first byte as a command.
- RESET_N asserted mid-transfer with FIFO non-empty -> all outputs immediately 0, EV_VALID=0. USER_IO_STATUS_EN build: cmd 0x1E with 0xEF, 0xBE, 0xAD, 0xDE -> STATUS=0xDEADBEEF.
